// File: rtl/password_enroll_pkg.sv
// Shared definitions for the password enrollment writer: FSM state encoding
// and the digit/boolean constants also used by the access checker.
package password_enroll_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CONFIRM = 3'd2,
        COMPARE = 3'd3,
        WRITE   = 3'd4,
        FAIL    = 3'd5
    } state_e;

    localparam logic YES = 1'b1;
    localparam logic NO  = 1'b0;

    localparam int DIGIT_W = 4;

endpackage

// File: rtl/password_enroll_shift_reg.sv
// Nibble shift register holding one entered code; the first digit shifted in
// ends up in the most significant nibble after DIGITS shifts.
module pass_shift_reg #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr_i,
    input  logic                      shift_i,
    input  logic [DIGIT_W-1:0]        digit_i,
    output logic [DIGITS*DIGIT_W-1:0] code_o
);

    logic [DIGITS*DIGIT_W-1:0] code_q;
    logic [DIGITS*DIGIT_W-1:0] code_d;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nib
            if (gi == 0) begin : g_lsn
                assign code_d[DIGIT_W-1:0] = digit_i;
            end else begin : g_upper
                assign code_d[gi*DIGIT_W +: DIGIT_W] = code_q[(gi-1)*DIGIT_W +: DIGIT_W];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_q <= '0;
        end else if (clr_i) begin
            code_q <= '0;
        end else if (shift_i) begin
            code_q <= code_d;
        end
    end

    assign code_o = code_q;

endmodule

// File: rtl/password_enroll.sv
// Enrollment FSM: collects a new code twice, checks it against the confirmation
// and the current password, and issues a single write strobe on success.
module password_enroll #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = password_enroll_pkg::DIGIT_W,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      accessFlag,
    input  logic                      changeReq,
    input  logic                      loadButton_s,
    input  logic [DIGIT_W-1:0]        passInput,
    input  logic [DIGITS*DIGIT_W-1:0] PASSWORD,
    output logic                      pwWrite,
    output logic [DIGITS*DIGIT_W-1:0] pwData,
    output logic                      busyFlag,
    output logic                      doneFlag,
    output logic                      errorFlag
);
    import password_enroll_pkg::*;

    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int CW     = $clog2(DIGITS + 1);
    localparam int IW     = $clog2(TIMEOUT_CYC);

    state_e              state_q, state_d;
    logic [CW-1:0]       digit_cnt_q, digit_cnt_d;
    logic [IW-1:0]       idle_cnt_q, idle_cnt_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                pw_write_q, pw_write_d;
    logic [CODE_W-1:0]   pw_data_q, pw_data_d;

    logic                shift_first, shift_second, clr_codes;
    logic [CODE_W-1:0]   first_code, second_code;
    logic                last_digit;

    pass_shift_reg #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) u_first (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr_codes),
        .shift_i (shift_first),
        .digit_i (passInput),
        .code_o  (first_code)
    );

    pass_shift_reg #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) u_second (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr_codes),
        .shift_i (shift_second),
        .digit_i (passInput),
        .code_o  (second_code)
    );

    assign last_digit = (digit_cnt_q == CW'(DIGITS - 1));

    always_comb begin
        state_d      = state_q;
        digit_cnt_d  = digit_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        done_d       = done_q;
        error_d      = error_q;
        pw_write_d   = NO;
        pw_data_d    = pw_data_q;
        shift_first  = NO;
        shift_second = NO;
        clr_codes    = NO;

        case (state_q)
            IDLE: begin
                if (changeReq == YES) begin
                    if (accessFlag == YES) begin
                        done_d      = NO;
                        error_d     = NO;
                        digit_cnt_d = '0;
                        idle_cnt_d  = '0;
                        state_d     = ENTRY;
                    end else begin
                        error_d = YES;
                    end
                end
            end
            ENTRY, CONFIRM: begin
                // Losing the session outranks everything; a press outranks the timeout.
                if (accessFlag != YES) begin
                    state_d = FAIL;
                end else if (loadButton_s == YES) begin
                    idle_cnt_d   = '0;
                    shift_first  = (state_q == ENTRY);
                    shift_second = (state_q == CONFIRM);
                    if (last_digit) begin
                        digit_cnt_d = '0;
                        state_d     = (state_q == ENTRY) ? CONFIRM : COMPARE;
                    end else begin
                        digit_cnt_d = digit_cnt_q + CW'(1);
                    end
                end else if (idle_cnt_q == IW'(TIMEOUT_CYC - 1)) begin
                    state_d = FAIL;
                end else if (idle_cnt_q != {IW{1'b1}}) begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end
            COMPARE: begin
                if (first_code != second_code || first_code == PASSWORD) begin
                    state_d = FAIL;
                end else begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                pw_write_d = YES;
                pw_data_d  = first_code;
                done_d     = YES;
                state_d    = IDLE;
            end
            FAIL: begin
                error_d     = YES;
                clr_codes   = YES;
                digit_cnt_d = '0;
                idle_cnt_d  = '0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            digit_cnt_q <= '0;
            idle_cnt_q  <= '0;
            done_q      <= NO;
            error_q     <= NO;
            pw_write_q  <= NO;
            pw_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            done_q      <= done_d;
            error_q     <= error_d;
            pw_write_q  <= pw_write_d;
            pw_data_q   <= pw_data_d;
        end
    end

    assign pwWrite   = pw_write_q;
    assign pwData    = pw_data_q;
    assign doneFlag  = done_q;
    assign errorFlag = error_q;
    assign busyFlag  = (state_q == ENTRY) || (state_q == CONFIRM) ||
                       (state_q == COMPARE) || (state_q == WRITE);

endmodule

// File: tb/tb_password_enroll.sv
// Directed and randomized enrollment sequences checked against an outcome model
// (accept iff both entries match and differ from the stored password).
module tb_password_enroll;

    localparam int DIGITS      = 4;
    localparam int DIGIT_W     = 4;
    localparam int TIMEOUT_CYC = 8;

    logic        clk          = 1'b0;
    logic        rst          = 1'b0;
    logic        accessFlag   = 1'b0;
    logic        changeReq    = 1'b0;
    logic        loadButton_s = 1'b0;
    logic [3:0]  passInput    = 4'h0;
    logic [15:0] PASSWORD     = 16'h1234;
    logic        pwWrite;
    logic [15:0] pwData;
    logic        busyFlag;
    logic        doneFlag;
    logic        errorFlag;

    int          checks    = 0;
    int          failures  = 0;
    int          wr_cnt    = 0;
    int          exp_wr    = 0;
    logic [15:0] last_data = 16'h0000;

    always #5 clk = ~clk;

    password_enroll #(
        .DIGITS      (DIGITS),
        .DIGIT_W     (DIGIT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .accessFlag   (accessFlag),
        .changeReq    (changeReq),
        .loadButton_s (loadButton_s),
        .passInput    (passInput),
        .PASSWORD     (PASSWORD),
        .pwWrite      (pwWrite),
        .pwData       (pwData),
        .busyFlag     (busyFlag),
        .doneFlag     (doneFlag),
        .errorFlag    (errorFlag)
    );

    always @(negedge clk) begin
        if (pwWrite === 1'b1) wr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        loadButton_s = 1'b1;
        passInput    = d;
        tick();
        loadButton_s = 1'b0;
        passInput    = $urandom_range(15, 0);
    endtask

    task automatic start();
        accessFlag = 1'b1;
        changeReq  = 1'b1;
        tick();
        changeReq  = 1'b0;
        check("start_busy", busyFlag, 1);
        check("start_done_clr", doneFlag, 0);
        check("start_err_clr", errorFlag, 0);
    endtask

    task automatic enter_digits(input logic [15:0] c, input int lo, input int hi, input int gap_max);
        for (int i = lo; i < hi; i++) begin
            repeat ($urandom_range(gap_max, 0)) tick();
            press(c[15-4*i -: 4]);
        end
    endtask

    // Called right after the edge that sampled the final confirm digit.
    task automatic finish_check(input logic [15:0] first, input logic [15:0] second);
        logic ok;
        ok = (first == second) && (first != PASSWORD);
        check("compare_busy", busyFlag, 1);
        check("compare_nowr", pwWrite, 0);
        tick();
        check("decide_busy", busyFlag, ok);
        check("decide_nowr", pwWrite, 0);
        tick();
        if (ok) begin
            last_data = first;
            exp_wr++;
        end
        check("pwWrite", pwWrite, ok);
        check("pwData", pwData, last_data);
        check("done", doneFlag, ok);
        check("error", errorFlag, !ok);
        check("idle_busy", busyFlag, 0);
        tick();
        check("write_single", pwWrite, 0);
        check("write_count", wr_cnt, exp_wr);
        $display("enroll first=%h second=%h password=%h outcome=%s writes=%0d",
                 first, second, PASSWORD, ok ? "write" : "reject", wr_cnt);
    endtask

    task automatic enroll(input logic [15:0] first, input logic [15:0] second, input int gap_max);
        start();
        enter_digits(first, 0, 4, gap_max);
        enter_digits(second, 0, 4, gap_max);
        finish_check(first, second);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        int          kind;

        // Reset state
        repeat (3) tick();
        check("rst_pwWrite", pwWrite, 0);
        check("rst_pwData", pwData, 0);
        check("rst_busy", busyFlag, 0);
        check("rst_done", doneFlag, 0);
        check("rst_error", errorFlag, 0);
        rst = 1'b1;
        tick();

        // Valid change, mismatch, reuse of current code
        enroll(16'h5678, 16'h5678, 0);

        accessFlag = 1'b0;
        changeReq  = 1'b1;
        tick();
        changeReq  = 1'b0;
        check("denied_error", errorFlag, 1);
        check("denied_busy", busyFlag, 0);
        check("denied_done_held", doneFlag, 1);
        tick();
        check("denied_stay_idle", busyFlag, 0);
        $display("denied changeReq error=%0d busy=%0d", errorFlag, busyFlag);

        enroll(16'h5678, 16'h5679, 0);
        enroll(16'h1234, 16'h1234, 1);

        // Timeout after two digits
        start();
        enter_digits(16'h4321, 0, 2, 0);
        repeat (7) tick();
        check("to_alive_7", busyFlag, 1);
        check("to_noerr_7", errorFlag, 0);
        tick();
        check("to_fail_busy", busyFlag, 0);
        tick();
        check("to_error", errorFlag, 1);
        check("to_nowr", pwWrite, 0);
        tick();
        check("to_write_count", wr_cnt, exp_wr);
        $display("timeout entry error=%0d busy=%0d", errorFlag, busyFlag);

        // Press on the 7th idle cycle keeps the entry alive
        start();
        enter_digits(16'h4321, 0, 2, 0);
        repeat (6) tick();
        press(4'h2);
        check("to_saved_busy", busyFlag, 1);
        enter_digits(16'h4321, 3, 4, 0);
        enter_digits(16'h4321, 0, 4, 0);
        finish_check(16'h4321, 16'h4321);

        // Session lost mid-confirm
        start();
        enter_digits(16'hABCD, 0, 4, 1);
        enter_digits(16'hABCD, 0, 2, 1);
        accessFlag = 1'b0;
        tick();
        check("drop_busy", busyFlag, 0);
        tick();
        check("drop_error", errorFlag, 1);
        check("drop_nowr", pwWrite, 0);
        accessFlag = 1'b1;
        tick();
        check("drop_write_count", wr_cnt, exp_wr);
        $display("access drop in confirm error=%0d writes=%0d", errorFlag, wr_cnt);

        // Reset after three confirm digits, then a fresh valid sequence
        start();
        enter_digits(16'h2468, 0, 4, 0);
        enter_digits(16'h2468, 0, 3, 0);
        rst = 1'b0;
        tick();
        check("midrst_busy", busyFlag, 0);
        check("midrst_pwData", pwData, 0);
        check("midrst_done", doneFlag, 0);
        tick();
        rst = 1'b1;
        last_data = 16'h0000;
        tick();
        check("midrst_nowr", wr_cnt, exp_wr);
        $display("reset mid-confirm writes=%0d", wr_cnt);
        enroll(16'h9999, 16'h9999, 0);

        // Randomized enrollments
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(2, 0);
            a = 16'($urandom);
            if (kind == 0) begin
                b = a;
            end else if (kind == 1) begin
                b = a ^ (16'h1 << $urandom_range(15, 0));
            end else begin
                a = PASSWORD;
                b = PASSWORD;
            end
            enroll(a, b, 5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
